// File: rtl/sar_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sar_seq_ctrl
//   SAR conversion controller with a multi-channel scan sequencer.
//   Samples each channel enabled in the latched mask (ascending index), then
//   resolves WIDTH bits MSB first by driving trial codes into the capacitive
//   DAC and reading back the comparator. Scans once, or continuously while
//   'cont' is high at the end of each scan.
//
//   Optional build macro: SAR_CMP_SYNC_EN
//     defined   - cmp_i passes through a 2-flop synchronizer; each bit step
//                 takes 3 cycles (drive, wait, wait/decide).
//     undefined - cmp_i is already synchronous; each bit step takes 1 cycle.
//
// Ports
//   clk         in   conversion clock
//   rstn        in   asynchronous active-low reset
//   start       in   level; begins a scan when sampled high in IDLE
//   cont        in   1 = rescan continuously (sampled at end of each scan)
//   ch_mask     in   channel enables, latched at scan start
//   cmp_i       in   comparator: 1 = Vin >= Vdac (keep trial bit)
//   sample_o    out  high during the sample phase
//   ch_sel_o    out  analog mux select (current channel)
//   dac_code_o  out  DAC trial code
//   data_o      out  last converted result
//   data_ch_o   out  channel index of data_o
//   valid_o     out  1-cycle pulse: data_o/data_ch_o updated
//   done_o      out  1-cycle pulse: scan complete
//   busy_o      out  high from scan start until the scan ends
// -----------------------------------------------------------------------------
module sar_seq_ctrl #(
    parameter int WIDTH         = 8,
    parameter int NCH           = 4,
    parameter int SAMPLE_CYCLES = 2,
    localparam int CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             cont,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             cmp_i,
    output logic             sample_o,
    output logic [CHW-1:0]   ch_sel_o,
    output logic [WIDTH-1:0] dac_code_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CHW-1:0]   data_ch_o,
    output logic             valid_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2
    } state_t;

    state_t           state_r,   state_s;
    logic [NCH-1:0]   mask_r,    mask_s;
    logic [CHW-1:0]   ch_r,      ch_s;
    logic [CW-1:0]    cnt_r,     cnt_s;
    logic [BW-1:0]    bit_r,     bit_s;
    logic [WIDTH-1:0] res_r,     res_s;
    logic             sample_r,  sample_s;
    logic [WIDTH-1:0] dac_r,     dac_s;
    logic [WIDTH-1:0] data_r,    data_s;
    logic [CHW-1:0]   data_ch_r, data_ch_s;
    logic             valid_r,   valid_s;
    logic             done_r,    done_s;
    logic             busy_r,    busy_s;

    logic             step_last_s;   // last cycle of the current bit step
    logic             cmp_dec_s;     // comparator decision used at step end
    logic [WIDTH-1:0] res_new_s;     // result with the current bit resolved
    logic [CHW:0]     first_s;       // {found, idx} lowest enabled in ch_mask
    logic [CHW:0]     next_s;        // {found, idx} next enabled after ch_r

    // Lowest enabled channel with index >= from; MSB of result is 'found'.
    function automatic logic [CHW:0] next_enabled(input logic [NCH-1:0] mask,
                                                   input logic [CHW:0]   from);
        logic [CHW:0] r;
        r = {(CHW+1){1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r = {1'b1, CHW'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

`ifdef SAR_CMP_SYNC_EN
    logic [1:0] sync_r;
    logic [1:0] sub_r;

    // Two-flop synchronizer on the asynchronous comparator output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], cmp_i};
        end
    end

    // Sub-cycle counter within a 3-cycle bit step; idles at 0 outside CONVERT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sub_r <= 2'd0;
        end else if ((state_r == ST_CONVERT) && (sub_r != 2'd2)) begin
            sub_r <= sub_r + 2'd1;
        end else begin
            sub_r <= 2'd0;
        end
    end

    assign step_last_s = (sub_r == 2'd2);
    assign cmp_dec_s   = sync_r[1];
`else
    assign step_last_s = 1'b1;
    assign cmp_dec_s   = cmp_i;
`endif

    // dac_r already holds res_r | trial bit, so keeping the bit is just dac_r.
    assign res_new_s = cmp_dec_s ? dac_r : res_r;
    assign first_s   = next_enabled(ch_mask, {(CHW+1){1'b0}});
    assign next_s    = next_enabled(mask_r, {1'b0, ch_r} + {{CHW{1'b0}}, 1'b1});

    // Next-state and next-output computation for the scan/convert FSM.
    always_comb begin
        state_s   = state_r;
        mask_s    = mask_r;
        ch_s      = ch_r;
        cnt_s     = cnt_r;
        bit_s     = bit_r;
        res_s     = res_r;
        sample_s  = sample_r;
        dac_s     = dac_r;
        data_s    = data_r;
        data_ch_s = data_ch_r;
        valid_s   = 1'b0;
        done_s    = 1'b0;
        busy_s    = busy_r;

        case (state_r)
            ST_IDLE: begin
                sample_s = 1'b0;
                dac_s    = {WIDTH{1'b0}};
                busy_s   = 1'b0;
                if (start && (ch_mask != {NCH{1'b0}})) begin
                    state_s  = ST_SAMPLE;
                    mask_s   = ch_mask;
                    ch_s     = first_s[CHW-1:0];
                    cnt_s    = {CW{1'b0}};
                    sample_s = 1'b1;
                    busy_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_SAMPLE: begin
                if (cnt_r == CW'(SAMPLE_CYCLES - 1)) begin
                    state_s  = ST_CONVERT;
                    sample_s = 1'b0;
                    bit_s    = BW'(WIDTH - 1);
                    res_s    = {WIDTH{1'b0}};
                    dac_s    = ONE << (WIDTH - 1);
                end else begin
                    cnt_s    = cnt_r + CW'(1);
                end
            end

            ST_CONVERT: begin
                if (step_last_s) begin
                    if (bit_r == {BW{1'b0}}) begin
                        // Result cycle: doubles as first SAMPLE of what follows.
                        valid_s   = 1'b1;
                        data_s    = res_new_s;
                        data_ch_s = ch_r;
                        dac_s     = {WIDTH{1'b0}};
                        res_s     = {WIDTH{1'b0}};
                        cnt_s     = {CW{1'b0}};
                        if (next_s[CHW]) begin
                            state_s  = ST_SAMPLE;
                            ch_s     = next_s[CHW-1:0];
                            sample_s = 1'b1;
                        end else begin
                            done_s = 1'b1;
                            if (cont && (ch_mask != {NCH{1'b0}})) begin
                                state_s  = ST_SAMPLE;
                                mask_s   = ch_mask;
                                ch_s     = first_s[CHW-1:0];
                                sample_s = 1'b1;
                            end else begin
                                state_s  = ST_IDLE;
                                busy_s   = 1'b0;
                                sample_s = 1'b0;
                            end
                        end
                    end else begin
                        res_s = res_new_s;
                        bit_s = bit_r - BW'(1);
                        dac_s = res_new_s | (ONE << (bit_r - BW'(1)));
                    end
                end else begin
                    state_s = ST_CONVERT;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                sample_s = 1'b0;
                dac_s    = {WIDTH{1'b0}};
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any conversion silently.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            mask_r    <= {NCH{1'b0}};
            ch_r      <= {CHW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            bit_r     <= {BW{1'b0}};
            res_r     <= {WIDTH{1'b0}};
            sample_r  <= 1'b0;
            dac_r     <= {WIDTH{1'b0}};
            data_r    <= {WIDTH{1'b0}};
            data_ch_r <= {CHW{1'b0}};
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            mask_r    <= mask_s;
            ch_r      <= ch_s;
            cnt_r     <= cnt_s;
            bit_r     <= bit_s;
            res_r     <= res_s;
            sample_r  <= sample_s;
            dac_r     <= dac_s;
            data_r    <= data_s;
            data_ch_r <= data_ch_s;
            valid_r   <= valid_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
        end
    end

    assign sample_o   = sample_r;
    assign ch_sel_o   = ch_r;
    assign dac_code_o = dac_r;
    assign data_o     = data_r;
    assign data_ch_o  = data_ch_r;
    assign valid_o    = valid_r;
    assign done_o     = done_r;
    assign busy_o     = busy_r;

endmodule
